// File: rtl/assoc_table_ctrl.sv
`default_nettype none
// =============================================================================
// Module   : assoc_table_ctrl
// Desc     : Scanning sequencer for a small signed-key associative table with
//            write/read/delete/size/low/high/next/clear commands.
//            Optional macro ASSOC_TABLE_STATS_EN adds hit/miss counters.
// Revision : 1.0
// =============================================================================
module assoc_table_ctrl #(
    parameter  int DEPTH = 8,
    parameter  int KEY_W = 32,
    parameter  int VAL_W = 32,
    localparam int IDX_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [2:0]       cmd_op,
    input  logic [KEY_W-1:0] cmd_key,
    input  logic [VAL_W-1:0] cmd_val,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_found,
    output logic             rsp_err,
    output logic [KEY_W-1:0] rsp_key,
    output logic [VAL_W-1:0] rsp_val,
    output logic [IDX_W:0]   rsp_size
`ifdef ASSOC_TABLE_STATS_EN
    ,
    output logic [15:0]      stat_hits,
    output logic [15:0]      stat_misses
`endif
);

    localparam logic [2:0] c_OP_WRITE  = 3'd0;
    localparam logic [2:0] c_OP_READ   = 3'd1;
    localparam logic [2:0] c_OP_DELETE = 3'd2;
    localparam logic [2:0] c_OP_SIZE   = 3'd3;
    localparam logic [2:0] c_OP_LOW    = 3'd4;
    localparam logic [2:0] c_OP_HIGH   = 3'd5;
    localparam logic [2:0] c_OP_NEXT   = 3'd6;
    localparam logic [2:0] c_OP_CLEAR  = 3'd7;
    localparam logic [IDX_W-1:0] c_LAST_IDX = IDX_W'(DEPTH - 1);

    typedef enum logic [1:0] {S_IDLE = 2'd0, S_SCAN = 2'd1, S_RESP = 2'd2} state_t;

    state_t                   state_q, state_d;
    logic [IDX_W-1:0]         idx_q, idx_d;
    logic [2:0]               op_q, op_d;
    logic signed [KEY_W-1:0]  key_q, key_d;
    logic [VAL_W-1:0]         val_q, val_d;
    logic [DEPTH-1:0]         valid_q, valid_d;
    logic [IDX_W:0]           count_q, count_d;

    logic                     m_found_q, m_found_d, f_found_q, f_found_d, b_found_q, b_found_d;
    logic [IDX_W-1:0]         m_idx_q, m_idx_d, f_idx_q, f_idx_d;
    logic [VAL_W-1:0]         m_val_q, m_val_d, b_val_q, b_val_d;
    logic signed [KEY_W-1:0]  b_key_q, b_key_d;

    logic                     cmd_ready_q, cmd_ready_d, rsp_valid_q, rsp_valid_d;
    logic                     rsp_found_q, rsp_found_d, rsp_err_q, rsp_err_d;
    logic [KEY_W-1:0]         rsp_key_q, rsp_key_d;
    logic [VAL_W-1:0]         rsp_val_q, rsp_val_d;
    logic [IDX_W:0]           rsp_size_q, rsp_size_d;

    logic [KEY_W-1:0]         mem_key_q [DEPTH];
    logic [VAL_W-1:0]         mem_val_q [DEPTH];
    logic                     mem_we;
    logic [IDX_W-1:0]         mem_widx;

    // Trackers folded with the slot under examination this cycle
    logic                     slot_v, w_match, w_better;
    logic signed [KEY_W-1:0]  slot_key;
    logic [VAL_W-1:0]         slot_val;
    logic                     w_m_found, w_f_found, w_b_found;
    logic [IDX_W-1:0]         w_m_idx, w_f_idx;
    logic [VAL_W-1:0]         w_m_val, w_b_val;
    logic signed [KEY_W-1:0]  w_b_key;

    always_comb begin
        slot_v    = valid_q[idx_q];
        slot_key  = $signed(mem_key_q[idx_q]);
        slot_val  = mem_val_q[idx_q];
        w_match   = slot_v && (slot_key == key_q);
        w_m_found = m_found_q || w_match;
        w_m_idx   = w_match ? idx_q : m_idx_q;
        w_m_val   = w_match ? slot_val : m_val_q;
        w_f_found = f_found_q || !slot_v;
        w_f_idx   = (!f_found_q && !slot_v) ? idx_q : f_idx_q;
        case (op_q)
            c_OP_LOW:  w_better = slot_v && (!b_found_q || slot_key < b_key_q);
            c_OP_HIGH: w_better = slot_v && (!b_found_q || slot_key > b_key_q);
            c_OP_NEXT: w_better = slot_v && (slot_key > key_q) && (!b_found_q || slot_key < b_key_q);
            default:   w_better = 1'b0;
        endcase
        w_b_found = b_found_q || w_better;
        w_b_key   = w_better ? slot_key : b_key_q;
        w_b_val   = w_better ? slot_val : b_val_q;
    end

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        op_d        = op_q;
        key_d       = key_q;
        val_d       = val_q;
        valid_d     = valid_q;
        count_d     = count_q;
        m_found_d   = m_found_q;
        m_idx_d     = m_idx_q;
        m_val_d     = m_val_q;
        f_found_d   = f_found_q;
        f_idx_d     = f_idx_q;
        b_found_d   = b_found_q;
        b_key_d     = b_key_q;
        b_val_d     = b_val_q;
        cmd_ready_d = cmd_ready_q;
        rsp_valid_d = rsp_valid_q;
        rsp_found_d = rsp_found_q;
        rsp_err_d   = rsp_err_q;
        rsp_key_d   = rsp_key_q;
        rsp_val_d   = rsp_val_q;
        rsp_size_d  = rsp_size_q;
        mem_we      = 1'b0;
        mem_widx    = '0;

        case (state_q)
            S_IDLE: begin
                if (cmd_valid && cmd_ready_q) begin
                    op_d        = cmd_op;
                    key_d       = $signed(cmd_key);
                    val_d       = cmd_val;
                    idx_d       = '0;
                    m_found_d   = 1'b0;
                    m_idx_d     = '0;
                    m_val_d     = '0;
                    f_found_d   = 1'b0;
                    f_idx_d     = '0;
                    b_found_d   = 1'b0;
                    b_key_d     = '0;
                    b_val_d     = '0;
                    cmd_ready_d = 1'b0;
                    if (cmd_op == c_OP_SIZE || cmd_op == c_OP_CLEAR) begin
                        if (cmd_op == c_OP_CLEAR) begin
                            valid_d = '0;
                            count_d = '0;
                        end
                        state_d     = S_RESP;
                        rsp_valid_d = 1'b1;
                        rsp_found_d = (cmd_op == c_OP_SIZE) && (count_q != '0);
                        rsp_err_d   = 1'b0;
                        rsp_key_d   = '0;
                        rsp_val_d   = '0;
                        rsp_size_d  = count_d;
                    end else begin
                        state_d = S_SCAN;
                    end
                end
            end
            S_SCAN: begin
                if (idx_q != c_LAST_IDX) begin
                    idx_d     = idx_q + 1'b1;
                    m_found_d = w_m_found;
                    m_idx_d   = w_m_idx;
                    m_val_d   = w_m_val;
                    f_found_d = w_f_found;
                    f_idx_d   = w_f_idx;
                    b_found_d = w_b_found;
                    b_key_d   = w_b_key;
                    b_val_d   = w_b_val;
                end else begin
                    state_d     = S_RESP;
                    rsp_valid_d = 1'b1;
                    rsp_found_d = 1'b0;
                    rsp_err_d   = 1'b0;
                    rsp_key_d   = '0;
                    rsp_val_d   = '0;
                    case (op_q)
                        c_OP_WRITE: begin
                            if (w_m_found) begin
                                mem_we      = 1'b1;
                                mem_widx    = w_m_idx;
                                rsp_found_d = 1'b1;
                                rsp_key_d   = key_q;
                                rsp_val_d   = val_q;
                            end else if (w_f_found) begin
                                mem_we           = 1'b1;
                                mem_widx         = w_f_idx;
                                valid_d[w_f_idx] = 1'b1;
                                count_d          = count_q + 1'b1;
                                rsp_key_d        = key_q;
                                rsp_val_d        = val_q;
                            end else begin
                                rsp_err_d = 1'b1;
                            end
                        end
                        c_OP_READ, c_OP_DELETE: begin
                            if (w_m_found) begin
                                rsp_found_d = 1'b1;
                                rsp_key_d   = key_q;
                                rsp_val_d   = w_m_val;
                                if (op_q == c_OP_DELETE) begin
                                    valid_d[w_m_idx] = 1'b0;
                                    count_d          = count_q - 1'b1;
                                end
                            end
                        end
                        default: begin
                            rsp_found_d = w_b_found;
                            rsp_key_d   = w_b_key;
                            rsp_val_d   = w_b_val;
                        end
                    endcase
                    rsp_size_d = count_d;
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    state_d     = S_IDLE;
                    rsp_valid_d = 1'b0;
                    cmd_ready_d = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            idx_q       <= '0;
            op_q        <= '0;
            key_q       <= '0;
            val_q       <= '0;
            valid_q     <= '0;
            count_q     <= '0;
            m_found_q   <= 1'b0;
            m_idx_q     <= '0;
            m_val_q     <= '0;
            f_found_q   <= 1'b0;
            f_idx_q     <= '0;
            b_found_q   <= 1'b0;
            b_key_q     <= '0;
            b_val_q     <= '0;
            cmd_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_found_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_key_q   <= '0;
            rsp_val_q   <= '0;
            rsp_size_q  <= '0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            op_q        <= op_d;
            key_q       <= key_d;
            val_q       <= val_d;
            valid_q     <= valid_d;
            count_q     <= count_d;
            m_found_q   <= m_found_d;
            m_idx_q     <= m_idx_d;
            m_val_q     <= m_val_d;
            f_found_q   <= f_found_d;
            f_idx_q     <= f_idx_d;
            b_found_q   <= b_found_d;
            b_key_q     <= b_key_d;
            b_val_q     <= b_val_d;
            cmd_ready_q <= cmd_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_found_q <= rsp_found_d;
            rsp_err_q   <= rsp_err_d;
            rsp_key_q   <= rsp_key_d;
            rsp_val_q   <= rsp_val_d;
            rsp_size_q  <= rsp_size_d;
        end
    end

    // Slot payload is qualified by valid_q, so it needs no reset
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_key_q[mem_widx] <= key_q;
            mem_val_q[mem_widx] <= val_q;
        end
    end

    assign cmd_ready = cmd_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_found = rsp_found_q;
    assign rsp_err   = rsp_err_q;
    assign rsp_key   = rsp_key_q;
    assign rsp_val   = rsp_val_q;
    assign rsp_size  = rsp_size_q;

`ifdef ASSOC_TABLE_STATS_EN
    logic [15:0] stat_hits_q, stat_hits_d, stat_misses_q, stat_misses_d;

    always_comb begin
        stat_hits_d   = stat_hits_q;
        stat_misses_d = stat_misses_q;
        if (state_q == S_IDLE && cmd_valid && cmd_ready_q && cmd_op == c_OP_CLEAR) begin
            stat_hits_d   = '0;
            stat_misses_d = '0;
        end else if (state_q == S_RESP && rsp_ready &&
                     (op_q == c_OP_READ || op_q == c_OP_DELETE)) begin
            if (rsp_found_q && stat_hits_q != 16'hFFFF)
                stat_hits_d = stat_hits_q + 1'b1;
            else if (!rsp_found_q && stat_misses_q != 16'hFFFF)
                stat_misses_d = stat_misses_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_hits_q   <= '0;
            stat_misses_q <= '0;
        end else begin
            stat_hits_q   <= stat_hits_d;
            stat_misses_q <= stat_misses_d;
        end
    end

    assign stat_hits   = stat_hits_q;
    assign stat_misses = stat_misses_q;
`else
    // Statistics counters are not built in this configuration.
`endif

endmodule
`default_nettype wire

// File: tb/tb_assoc_table_ctrl.sv
`default_nettype none
// =============================================================================
// Module   : tb_assoc_table_ctrl
// Desc     : Directed self-checking bench for assoc_table_ctrl (DEPTH=8).
// Revision : 1.0
// =============================================================================
module tb_assoc_table_ctrl;

    localparam int DEPTH = 8;
    localparam int KEY_W = 32;
    localparam int VAL_W = 32;
    localparam int IDX_W = 3;

    localparam logic [2:0] OP_WRITE  = 3'd0;
    localparam logic [2:0] OP_READ   = 3'd1;
    localparam logic [2:0] OP_DELETE = 3'd2;
    localparam logic [2:0] OP_SIZE   = 3'd3;
    localparam logic [2:0] OP_LOW    = 3'd4;
    localparam logic [2:0] OP_HIGH   = 3'd5;
    localparam logic [2:0] OP_NEXT   = 3'd6;
    localparam logic [2:0] OP_CLEAR  = 3'd7;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             cmd_valid;
    logic             cmd_ready;
    logic [2:0]       cmd_op;
    logic [KEY_W-1:0] cmd_key;
    logic [VAL_W-1:0] cmd_val;
    logic             rsp_valid;
    logic             rsp_ready;
    logic             rsp_found;
    logic             rsp_err;
    logic [KEY_W-1:0] rsp_key;
    logic [VAL_W-1:0] rsp_val;
    logic [IDX_W:0]   rsp_size;

    int n_checks = 0;
    int n_errors = 0;

    logic        g_found, g_err;
    logic [31:0] g_key, g_val;
    logic [31:0] g_size;
    int          g_lat;

    assoc_table_ctrl #(.DEPTH(DEPTH), .KEY_W(KEY_W), .VAL_W(VAL_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_key   (cmd_key),
        .cmd_val   (cmd_val),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_found (rsp_found),
        .rsp_err   (rsp_err),
        .rsp_key   (rsp_key),
        .rsp_val   (rsp_val),
        .rsp_size  (rsp_size)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Handshake one command and wait for its response (left pending)
    task automatic issue(input logic [2:0] op, input logic [31:0] key, input logic [31:0] val);
        int guard;
        @(negedge clk);
        cmd_op    = op;
        cmd_key   = key;
        cmd_val   = val;
        cmd_valid = 1'b1;
        guard = 0;
        while (!cmd_ready && guard < 40) begin
            @(negedge clk);
            guard++;
        end
        check_eq("cmd_ready_wait", 32'(cmd_ready), 1);
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        g_lat = 1;
        while (!rsp_valid && g_lat < 40) begin
            @(posedge clk);
            #1;
            g_lat++;
        end
        check_eq("rsp_valid_wait", 32'(rsp_valid), 1);
        g_found = rsp_found;
        g_err   = rsp_err;
        g_key   = rsp_key;
        g_val   = rsp_val;
        g_size  = 32'(rsp_size);
    endtask

    task automatic accept();
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        check_eq("rsp_valid_drop", 32'(rsp_valid), 0);
    endtask

    task automatic run(input logic [2:0] op, input logic [31:0] key, input logic [31:0] val);
        issue(op, key, val);
        accept();
    endtask

    initial begin
        int  any_rsp;
        rst_n     = 1'b0;
        cmd_valid = 1'b0;
        cmd_op    = '0;
        cmd_key   = '0;
        cmd_val   = '0;
        rsp_ready = 1'b0;
        #12;
        check_eq("rst_cmd_ready", 32'(cmd_ready), 1);
        check_eq("rst_rsp_valid", 32'(rsp_valid), 0);
        check_eq("rst_rsp_found", 32'(rsp_found), 0);
        check_eq("rst_rsp_err",   32'(rsp_err), 0);
        check_eq("rst_rsp_key",   rsp_key, 0);
        check_eq("rst_rsp_size",  32'(rsp_size), 0);
        @(negedge clk);
        rst_n = 1'b1;

        run(OP_SIZE, 0, 0);
        check_eq("size0_lat", g_lat, 1);
        check_eq("size0_found", 32'(g_found), 0);
        check_eq("size0_size", g_size, 0);

        run(OP_WRITE, 5, 100);
        check_eq("wr5_lat", g_lat, DEPTH + 1);
        check_eq("wr5_found", 32'(g_found), 0);
        check_eq("wr5_size", g_size, 1);
        run(OP_WRITE, 1, 200);
        check_eq("wr1_lat", g_lat, DEPTH + 1);
        check_eq("wr1_found", 32'(g_found), 0);
        run(OP_WRITE, 10, 300);
        check_eq("wr10_size", g_size, 3);
        run(OP_SIZE, 0, 0);
        check_eq("size3_size", g_size, 3);
        check_eq("size3_found", 32'(g_found), 1);

        run(OP_LOW, 0, 0);
        check_eq("low_key", g_key, 1);
        check_eq("low_val", g_val, 200);
        run(OP_HIGH, 0, 0);
        check_eq("high_key", g_key, 10);
        check_eq("high_val", g_val, 300);
        run(OP_NEXT, 1, 0);
        check_eq("next1_found", 32'(g_found), 1);
        check_eq("next1_key", g_key, 5);
        run(OP_NEXT, 10, 0);
        check_eq("next10_found", 32'(g_found), 0);
        check_eq("next10_key", g_key, 0);
        run(OP_READ, 7, 0);
        check_eq("rd7_found", 32'(g_found), 0);
        run(OP_READ, 10, 0);
        check_eq("rd10_found", 32'(g_found), 1);
        check_eq("rd10_val", g_val, 300);

        run(OP_WRITE, -3, 7);
        check_eq("wrm3_size", g_size, 4);
        run(OP_LOW, 0, 0);
        check_eq("lowm3_key", g_key, -3);
        check_eq("lowm3_val", g_val, 7);
        run(OP_NEXT, -100, 0);
        check_eq("nextm100_key", g_key, -3);
        run(OP_NEXT, -3, 0);
        check_eq("nextm3_key", g_key, 1);
        run(OP_DELETE, 5, 0);
        check_eq("del5_found", 32'(g_found), 1);
        check_eq("del5_size", g_size, 3);
        run(OP_DELETE, 5, 0);
        check_eq("del5b_found", 32'(g_found), 0);
        check_eq("del5b_err", 32'(g_err), 0);
        check_eq("del5b_size", g_size, 3);

        // Entries now {1,10,-3}; fill the remaining five slots
        for (int i = 0; i < 5; i++) run(OP_WRITE, 20 + 10 * i, 1000 + i);
        check_eq("fill_size", g_size, DEPTH);
        run(OP_WRITE, 99, 9);
        check_eq("full_err", 32'(g_err), 1);
        check_eq("full_found", 32'(g_found), 0);
        check_eq("full_size", g_size, DEPTH);
        run(OP_WRITE, 1, 55);
        check_eq("upd1_found", 32'(g_found), 1);
        check_eq("upd1_err", 32'(g_err), 0);
        check_eq("upd1_size", g_size, DEPTH);
        run(OP_READ, 1, 0);
        check_eq("rd1_val", g_val, 55);
        run(OP_READ, 40, 0);
        check_eq("rd40_val", g_val, 1002);
        run(OP_HIGH, 0, 0);
        check_eq("highfull_key", g_key, 60);
        run(OP_READ, 99, 0);
        check_eq("rd99_found", 32'(g_found), 0);

        // Back-pressure: response must hold while rsp_ready is low
        issue(OP_READ, 10, 0);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            check_eq("hold_valid", 32'(rsp_valid), 1);
            check_eq("hold_found", 32'(rsp_found), 1);
            check_eq("hold_key", rsp_key, 10);
            check_eq("hold_val", rsp_val, 300);
            check_eq("hold_size", 32'(rsp_size), DEPTH);
            check_eq("hold_cmd_ready", 32'(cmd_ready), 0);
        end
        accept();

        // Reset in the middle of a scan
        @(negedge clk);
        cmd_op    = OP_READ;
        cmd_key   = 1;
        cmd_valid = 1'b1;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("midrst_valid", 32'(rsp_valid), 0);
        check_eq("midrst_cmd_ready", 32'(cmd_ready), 1);
        @(negedge clk);
        rst_n = 1'b1;
        any_rsp = 0;
        for (int i = 0; i < DEPTH + 4; i++) begin
            @(posedge clk);
            #1;
            if (rsp_valid) any_rsp = 1;
        end
        check_eq("midrst_no_rsp", any_rsp, 0);
        run(OP_SIZE, 0, 0);
        check_eq("postrst_size", g_size, 0);
        check_eq("postrst_found", 32'(g_found), 0);
        run(OP_READ, 1, 0);
        check_eq("postrst_rd1", 32'(g_found), 0);

        // CLEAR empties the table with single-cycle latency
        run(OP_WRITE, 7, 70);
        check_eq("wr7_size", g_size, 1);
        run(OP_CLEAR, 0, 0);
        check_eq("clr_lat", g_lat, 1);
        check_eq("clr_size", g_size, 0);
        check_eq("clr_found", 32'(g_found), 0);
        run(OP_READ, 7, 0);
        check_eq("clr_rd7", 32'(g_found), 0);
        run(OP_LOW, 0, 0);
        check_eq("lowempty_found", 32'(g_found), 0);
        check_eq("lowempty_key", g_key, 0);
        check_eq("lowempty_val", g_val, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
